// File: rtl/radix_4_ntt_pe_pipe_if.sv
// Handshake and data bundle for the pipelined radix-4 NTT processing element.
// master = upstream/downstream environment, slave = the PE itself.
interface radix_4_ntt_pe_pipe_if #(
    parameter int N = 17
);
    logic         in_valid;
    logic         in_ready;
    logic         inv;
    logic [N-1:0] a0;
    logic [N-1:0] a1;
    logic [N-1:0] a2;
    logic [N-1:0] a3;
    logic [N-1:0] tf1;
    logic [N-1:0] tf2;
    logic [N-1:0] tf3;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] b0;
    logic [N-1:0] b1;
    logic [N-1:0] b2;
    logic [N-1:0] b3;
    logic         busy;

    modport master (
        output in_valid, inv, a0, a1, a2, a3, tf1, tf2, tf3, out_ready,
        input  in_ready, out_valid, b0, b1, b2, b3, busy
    );

    modport slave (
        input  in_valid, inv, a0, a1, a2, a3, tf1, tf2, tf3, out_ready,
        output in_ready, out_valid, b0, b1, b2, b3, busy
    );
endinterface

// File: rtl/radix_4_ntt_pe_pipe.sv
// Pipelined radix-4 NTT butterfly mod Q with per-lane twiddles.
// Stages: s1 input capture, s2 inverse pre-butterfly, s3 twiddle product,
// s4 modular reduction, out forward post-butterfly. Forward and inverse
// share the three twiddle multipliers; each vector carries its own inv bit.
module radix_4_ntt_pe_pipe #(
    parameter int N      = 17,
    parameter int Q      = 65537,
    parameter int W4     = 256,
    parameter int W4_INV = 65281
) (
    input logic                   clk,
    input logic                   rst,
    radix_4_ntt_pe_pipe_if.slave  pe
);
    // Acceptance edge to out_valid edge; fixed by the stage split below.
    localparam int LAT = 4;

    // Sum width: up to four canonical terms plus a 2Q offset for subtractions.
    localparam int              W      = N + 3;
    localparam logic [W-1:0]    Q_S    = W'(Q);
    localparam logic [W-1:0]    Q2_S   = W'(2 * Q);
    localparam logic [2*N-1:0]  Q_P    = (2 * N)'(Q);
    localparam logic [N-1:0]    W4_C   = N'(W4);
    localparam logic [N-1:0]    W4I_C  = N'(W4_INV);

    typedef logic [3:0][N-1:0] vec_t;

    // Reduce a full-width product to [0, Q).
    function automatic logic [N-1:0] mod_p(input logic [2*N-1:0] p);
        logic [2*N-1:0] r;
        r = p % Q_P;
        return r[N-1:0];
    endfunction

    // Reduce a guarded sum to [0, Q).
    function automatic logic [N-1:0] mod_s(input logic [W-1:0] s);
        logic [W-1:0] r;
        r = s % Q_S;
        return r[N-1:0];
    endfunction

    function automatic logic [W-1:0] ext(input logic [N-1:0] x);
        return {{(W-N){1'b0}}, x};
    endfunction

    function automatic logic [N-1:0] mulmod(input logic [N-1:0] x, input logic [N-1:0] y);
        return mod_p({{N{1'b0}}, x} * {{N{1'b0}}, y});
    endfunction

    // 4-point butterfly with root w. The 2Q offset is added before the
    // subtractions so the running sum never goes negative.
    function automatic vec_t bfly(input vec_t x, input logic [N-1:0] w);
        logic [N-1:0] t1;
        logic [N-1:0] t3;
        vec_t         y;
        t1   = mulmod(w, x[1]);
        t3   = mulmod(w, x[3]);
        y[0] = mod_s(ext(x[0]) + ext(x[1]) + ext(x[2]) + ext(x[3]));
        y[1] = mod_s(ext(x[0]) + ext(t1) + Q2_S - ext(x[2]) - ext(t3));
        y[2] = mod_s(ext(x[0]) + ext(x[2]) + Q2_S - ext(x[1]) - ext(x[3]));
        y[3] = mod_s(ext(x[0]) + ext(t3) + Q2_S - ext(t1) - ext(x[2]));
        return y;
    endfunction

    logic                  en;
    logic [LAT:0]          vld_q;
    logic [LAT-1:0]        inv_q;
    vec_t                  a_in;
    vec_t                  a_q;
    vec_t                  pre_d;
    vec_t                  x_q;
    vec_t                  red_d;
    vec_t                  r_q;
    vec_t                  post_d;
    vec_t                  b_q;
    logic [3:1][N-1:0]     tf_in;
    logic [3:1][N-1:0]     tf1_q;
    logic [3:1][N-1:0]     tf2_q;
    logic [3:1][2*N-1:0]   p_q;
    logic [N-1:0]          x0_q;

    // Whole pipe advances together; a stalled output freezes every stage.
    assign en           = !vld_q[LAT] || pe.out_ready;
    assign pe.in_ready  = en;
    assign pe.out_valid = vld_q[LAT];
    assign pe.busy      = |vld_q;
    assign pe.b0        = b_q[0];
    assign pe.b1        = b_q[1];
    assign pe.b2        = b_q[2];
    assign pe.b3        = b_q[3];

    assign a_in  = {pe.a3, pe.a2, pe.a1, pe.a0};
    assign tf_in = {pe.tf3, pe.tf2, pe.tf1};

    // Valid and mode bits shift alongside the data; bubbles are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            inv_q <= '0;
        end else if (en) begin
            vld_q <= {vld_q[LAT-1:0], pe.in_valid};
            inv_q <= {inv_q[LAT-2:0], pe.inv};
        end
    end

    // s1: capture coefficients and twiddles.
    always_ff @(posedge clk) begin
        if (en) begin
            a_q   <= a_in;
            tf1_q <= tf_in;
        end
    end

    // s2: inverse vectors get their butterfly before the twiddle multiply.
    assign pre_d = inv_q[0] ? bfly(a_q, W4I_C) : a_q;

    // s2 register: butterfly result (or raw data) plus twiddles.
    always_ff @(posedge clk) begin
        if (en) begin
            x_q   <= pre_d;
            tf2_q <= tf1_q;
        end
    end

    // s3/s4 lane 0: twiddle is 1, value passes straight through.
    always_ff @(posedge clk) begin
        if (en) begin
            x0_q <= x_q[0];
        end
    end
    assign red_d[0] = x0_q;

    // Lanes 1..3: shared multipliers, product registered, then reduced.
    for (genvar gi = 1; gi < 4; gi++) begin : g_lane
        // s3: full-width twiddle product.
        always_ff @(posedge clk) begin
            if (en) begin
                p_q[gi] <= {{N{1'b0}}, x_q[gi]} * {{N{1'b0}}, tf2_q[gi]};
            end
        end
        assign red_d[gi] = mod_p(p_q[gi]);
    end

    // s4: canonical twiddled values.
    always_ff @(posedge clk) begin
        if (en) begin
            r_q <= red_d;
        end
    end

    // Forward vectors get their butterfly after the twiddle multiply.
    assign post_d = inv_q[LAT-1] ? r_q : bfly(r_q, W4_C);

    // Output register: cleared on reset, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_q <= '0;
        end else if (en) begin
            b_q <= post_d;
        end
    end
endmodule

// File: tb/tb_radix_4_ntt_pe_pipe.sv
// Directed bench for radix_4_ntt_pe_pipe: reset, basis vectors, inverse and
// twiddles, streaming, backpressure and reset in flight.
module tb_radix_4_ntt_pe_pipe;
    localparam int     N = 17;
    localparam longint Q = 65537;

    typedef logic [3:0][N-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    radix_4_ntt_pe_pipe_if #(.N(N)) pe_if ();

    radix_4_ntt_pe_pipe #(
        .N(N), .Q(65537), .W4(256), .W4_INV(65281)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pe (pe_if)
    );

    function automatic vec_t mk(input longint v0, input longint v1, input longint v2, input longint v3);
        vec_t r;
        r[0] = N'(v0);
        r[1] = N'(v1);
        r[2] = N'(v2);
        r[3] = N'(v3);
        return r;
    endfunction

    // Reference straight from the butterfly equations, signed arithmetic.
    function automatic vec_t model(input bit inv_v, input vec_t a, input vec_t tf);
        longint x[4];
        longint y[4];
        longint w;
        vec_t   r;
        w = inv_v ? 65281 : 256;
        for (int k = 0; k < 4; k++) begin
            x[k] = longint'(a[k]);
            if (!inv_v && k > 0) x[k] = (x[k] * longint'(tf[k])) % Q;
        end
        y[0] = x[0] + x[1] + x[2] + x[3];
        y[1] = x[0] + w * x[1] - x[2] - w * x[3];
        y[2] = x[0] - x[1] + x[2] - x[3];
        y[3] = x[0] - w * x[1] - x[2] + w * x[3];
        for (int k = 0; k < 4; k++) begin
            y[k] = ((y[k] % Q) + Q) % Q;
            if (inv_v && k > 0) y[k] = (y[k] * longint'(tf[k])) % Q;
            r[k] = N'(y[k]);
        end
        return r;
    endfunction

    function automatic vec_t get_b();
        vec_t r;
        r[0] = pe_if.b0;
        r[1] = pe_if.b1;
        r[2] = pe_if.b2;
        r[3] = pe_if.b3;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit inv_v, input vec_t a, input vec_t tf);
        pe_if.inv = inv_v;
        pe_if.a0  = a[0];
        pe_if.a1  = a[1];
        pe_if.a2  = a[2];
        pe_if.a3  = a[3];
        pe_if.tf1 = tf[1];
        pe_if.tf2 = tf[2];
        pe_if.tf3 = tf[3];
    endtask

    // Push one vector into an idle pipe and report the result and its latency.
    task automatic send_one(input bit inv_v, input vec_t a, input vec_t tf,
                            output vec_t got, output int lat);
        got = '0;
        lat = -1;
        pe_if.out_ready = 1'b1;
        drive(inv_v, a, tf);
        pe_if.in_valid = 1'b1;
        tick();
        pe_if.in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (pe_if.out_valid === 1'b1) begin
                got = get_b();
                lat = k;
                break;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        bit seen = 1'b0;
        rst = 1'b1;
        pe_if.out_ready = 1'b1;
        drive(1'b0, mk(1, 0, 0, 0), mk(0, 1, 1, 1));
        pe_if.in_valid = 1'b1;
        tick();
        tick();
        tests++; if (pe_if.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b want=0", pe_if.out_valid); end
        tests++; if (pe_if.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", pe_if.busy); end
        tests++; if (get_b() !== vec_t'(0)) begin fails++; $display("FAIL reset_b got=%h want=0", get_b()); end
        rst = 1'b0;
        pe_if.in_valid = 1'b0;
        #1;
        tests++; if (pe_if.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b want=1", pe_if.in_ready); end
        for (int c = 0; c < 8; c++) begin
            tick();
            if (pe_if.out_valid !== 1'b0) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL reset_no_output got=%b want=0", seen); end
        tests++; if (pe_if.busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy got=%b want=0", pe_if.busy); end
        $display("[TB] reset: done");
    endtask

    task automatic test_forward_basis();
        vec_t a[3];
        vec_t e[3];
        vec_t tf;
        vec_t got;
        int   lat;
        tf   = mk(0, 1, 1, 1);
        a[0] = mk(1, 0, 0, 0); e[0] = mk(1, 1, 1, 1);
        a[1] = mk(0, 1, 0, 0); e[1] = mk(1, 256, 65536, 65281);
        a[2] = mk(1, 1, 1, 1); e[2] = mk(4, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            send_one(1'b0, a[i], tf, got, lat);
            $display("[TB] fwd_basis %0d a=%h b=%h lat=%0d", i, a[i], got, lat);
            tests++; if (lat !== 4) begin fails++; $display("FAIL fwd_latency_%0d got=%0d want=4", i, lat); end
            tests++; if (got !== e[i]) begin fails++; $display("FAIL fwd_basis_%0d got=%h want=%h", i, got, e[i]); end
        end
    endtask

    task automatic test_inverse_twiddle();
        vec_t got;
        vec_t e;
        int   lat;
        send_one(1'b1, mk(0, 1, 0, 0), mk(0, 1, 1, 1), got, lat);
        e = mk(1, 65281, 65536, 256);
        $display("[TB] inverse a=(0,1,0,0) b=%h lat=%0d", got, lat);
        tests++; if (lat !== 4) begin fails++; $display("FAIL inv_latency got=%0d want=4", lat); end
        tests++; if (got !== e) begin fails++; $display("FAIL inv_basis got=%h want=%h", got, e); end
        send_one(1'b0, mk(0, 1, 0, 0), mk(0, 2, 1, 1), got, lat);
        e = mk(2, 512, 65535, 65025);
        $display("[TB] twiddle tf1=2 b=%h lat=%0d", got, lat);
        tests++; if (got !== e) begin fails++; $display("FAIL twiddle_tf1 got=%h want=%h", got, e); end
        send_one(1'b1, mk(0, 1, 0, 0), mk(0, 2, 3, 5), got, lat);
        e = mk(1, 65025, 65534, 1280);
        $display("[TB] inverse tf=(2,3,5) b=%h", got);
        tests++; if (got !== e) begin fails++; $display("FAIL inv_twiddle got=%h want=%h", got, e); end
    endtask

    task automatic make_vec(input int i, output bit inv_v, output vec_t a, output vec_t tf);
        inv_v = i[0];
        for (int k = 0; k < 4; k++) begin
            a[k]  = N'((longint'(i) * 7919 + longint'(k) * 40503 + 3) % Q);
            tf[k] = N'((longint'(i) * 1237 + longint'(k) * 911 + 1) % Q);
        end
        if (i == 0) a  = mk(Q - 1, Q - 1, Q - 1, Q - 1);
        if (i == 1) tf = mk(0, Q - 1, Q - 1, Q - 1);
    endtask

    task automatic test_back_to_back();
        bit   sinv[8];
        vec_t sa[8];
        vec_t stf[8];
        vec_t exp_b[8];
        int   sent = 0;
        int   got = 0;
        int   first_c = -1;
        int   last_c = -1;
        for (int i = 0; i < 8; i++) begin
            make_vec(i, sinv[i], sa[i], stf[i]);
            exp_b[i] = model(sinv[i], sa[i], stf[i]);
        end
        for (int c = 0; c < 30; c++) begin
            pe_if.out_ready = 1'b1;
            #1;
            if (pe_if.out_valid === 1'b1) begin
                tests++;
                if (got < 8) begin
                    $display("[TB] stream out %0d inv=%0d b=%h cycle=%0d", got, sinv[got], get_b(), c);
                    if (get_b() !== exp_b[got]) begin fails++; $display("FAIL stream_%0d got=%h want=%h", got, get_b(), exp_b[got]); end
                    if (first_c < 0) first_c = c;
                    last_c = c;
                end else begin
                    fails++; $display("FAIL stream_extra got=%h want=none", get_b());
                end
                got++;
            end
            if (sent < 8) begin
                drive(sinv[sent], sa[sent], stf[sent]);
                pe_if.in_valid = 1'b1;
                if (pe_if.in_ready === 1'b1) sent++;
            end else begin
                pe_if.in_valid = 1'b0;
            end
            tick();
        end
        pe_if.in_valid = 1'b0;
        tests++; if (got !== 8) begin fails++; $display("FAIL stream_count got=%0d want=8", got); end
        tests++; if (first_c !== 5) begin fails++; $display("FAIL stream_first_cycle got=%0d want=5", first_c); end
        tests++; if (last_c - first_c !== 7) begin fails++; $display("FAIL stream_consecutive got=%0d want=7", last_c - first_c); end
    endtask

    task automatic test_backpressure();
        bit   sinv[6];
        vec_t sa[6];
        vec_t stf[6];
        vec_t exp_b[6];
        vec_t held;
        int   sent = 0;
        int   got = 0;
        held = '0;
        for (int i = 0; i < 6; i++) begin
            make_vec(i + 2, sinv[i], sa[i], stf[i]);
            exp_b[i] = model(sinv[i], sa[i], stf[i]);
        end
        for (int c = 0; c < 30; c++) begin
            pe_if.out_ready = (c >= 5 && c <= 7) ? 1'b0 : 1'b1;
            #1;
            if (c >= 5 && c <= 7) begin
                $display("[TB] stall cycle %0d in_ready=%b out_valid=%b b=%h", c, pe_if.in_ready, pe_if.out_valid, get_b());
                tests++; if (pe_if.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_c%0d got=%b want=0", c, pe_if.in_ready); end
                tests++; if (pe_if.out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid_c%0d got=%b want=1", c, pe_if.out_valid); end
                if (c == 5) held = get_b();
                else begin
                    tests++; if (get_b() !== held) begin fails++; $display("FAIL bp_hold_c%0d got=%h want=%h", c, get_b(), held); end
                end
            end
            if (pe_if.out_valid === 1'b1 && pe_if.out_ready === 1'b1) begin
                tests++;
                if (got < 6) begin
                    $display("[TB] bp out %0d b=%h cycle=%0d", got, get_b(), c);
                    if (get_b() !== exp_b[got]) begin fails++; $display("FAIL bp_order_%0d got=%h want=%h", got, get_b(), exp_b[got]); end
                end else begin
                    fails++; $display("FAIL bp_extra got=%h want=none", get_b());
                end
                got++;
            end
            if (sent < 6) begin
                drive(sinv[sent], sa[sent], stf[sent]);
                pe_if.in_valid = 1'b1;
                if (pe_if.in_ready === 1'b1) sent++;
            end else begin
                pe_if.in_valid = 1'b0;
            end
            tick();
        end
        pe_if.in_valid = 1'b0;
        tests++; if (got !== 6) begin fails++; $display("FAIL bp_count got=%0d want=6", got); end
    endtask

    task automatic test_reset_midstream();
        bit   inv_v;
        vec_t a;
        vec_t tf;
        bit   seen = 1'b0;
        pe_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            make_vec(i + 10, inv_v, a, tf);
            drive(inv_v, a, tf);
            pe_if.in_valid = 1'b1;
            tick();
        end
        pe_if.in_valid = 1'b0;
        tests++; if (pe_if.busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before got=%b want=1", pe_if.busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("[TB] mid reset out_valid=%b busy=%b", pe_if.out_valid, pe_if.busy);
        tests++; if (pe_if.out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid got=%b want=0", pe_if.out_valid); end
        tests++; if (pe_if.busy !== 1'b0) begin fails++; $display("FAIL mid_busy got=%b want=0", pe_if.busy); end
        tests++; if (get_b() !== vec_t'(0)) begin fails++; $display("FAIL mid_b got=%h want=0", get_b()); end
        for (int c = 0; c < 12; c++) begin
            tick();
            if (pe_if.out_valid !== 1'b0) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL mid_discard got=%b want=0", seen); end
    endtask

    initial begin
        pe_if.in_valid  = 1'b0;
        pe_if.out_ready = 1'b1;
        drive(1'b0, '0, '0);
        test_reset();
        test_forward_basis();
        test_inverse_twiddle();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
